// File: rtl/prog_delay_line.sv
//-----------------------------------------------------------------------------
// Module   : prog_delay_line
// Purpose  : Multi-lane delay buffer with a run-time programmable delay.
//            Each sample accepted with en_i reappears on out_o exactly
//            delay_q_o accepted samples later. out_valid_o tracks whether
//            enough samples have been accepted since the last flush, and
//            out_o is zeroed while it is low.
// Ports    : clk_i        rising-edge clock
//            rst_ni       asynchronous active-low reset
//            en_i         accept in_i and advance the write pointer
//            in_i         LANES*WIDTH input; lane k at [k*WIDTH +: WIDTH]
//            cfg_we_i     load cfg_delay_i (clamped to MAX_DELAY) and flush
//            cfg_delay_i  requested delay
//            delay_q_o    active delay
//            out_o        delayed data, same lane packing as in_i
//            out_valid_o  out_o carries real delayed data
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module prog_delay_line #(
  parameter int WIDTH         = 24,
  parameter int LANES         = 2,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 64,
  localparam int DW           = $clog2(MAX_DELAY + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [LANES*WIDTH-1:0] in_i,
  input  logic                   cfg_we_i,
  input  logic [DW-1:0]          cfg_delay_i,
  output logic [DW-1:0]          delay_q_o,
  output logic [LANES*WIDTH-1:0] out_o,
  output logic                   out_valid_o
);

  localparam int              AW      = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int              DATA_W  = LANES * WIDTH;
  localparam logic [DW-1:0]   MAX_D   = DW'(MAX_DELAY);
  localparam logic [DW-1:0]   DEF_D   = DW'(DEFAULT_DELAY);
  localparam logic [AW-1:0]   WP_LAST = AW'(MAX_DELAY - 1);
  localparam logic [DW:0]     MAX_E   = (DW + 1)'(MAX_DELAY);

  logic [DATA_W-1:0] mem_q [MAX_DELAY];

  logic [AW-1:0] wp_q, wp_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] delay_q, delay_d;

  logic [AW-1:0] rp;
  logic [DW:0]   wp_e, del_e, rp_e;

  // Read address = wp - delay modulo MAX_DELAY. MAX_DELAY need not be a
  // power of two, so the wrap is done explicitly in a one-bit-wider domain.
  // With delay == MAX_DELAY this lands on wp itself, and because the read is
  // combinational the oldest entry is seen before it is overwritten.
  always_comb begin
    wp_e  = (DW + 1)'(wp_q);
    del_e = {1'b0, delay_q};
    if (wp_e >= del_e) begin
      rp_e = wp_e - del_e;
    end else begin
      rp_e = wp_e + MAX_E - del_e;
    end
    rp = AW'(rp_e);
  end

  always_comb begin
    wp_d    = wp_q;
    fill_d  = fill_q;
    delay_d = delay_q;

    if (en_i) begin
      wp_d = (wp_q == WP_LAST) ? '0 : wp_q + AW'(1);
    end

    // A reconfigure flushes: a sample pushed in the same cycle is still
    // written (wp advances) but is not counted towards the new fill.
    if (cfg_we_i) begin
      delay_d = (cfg_delay_i > MAX_D) ? MAX_D : cfg_delay_i;
      fill_d  = '0;
    end else if (en_i && (fill_q != MAX_D)) begin
      fill_d = fill_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q    <= '0;
      fill_q  <= '0;
      delay_q <= DEF_D;
    end else begin
      wp_q    <= wp_d;
      fill_q  <= fill_d;
      delay_q <= delay_d;
    end
  end

  // Storage is deliberately not reset; the fill gate keeps stale or
  // uninitialised contents off the output.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[wp_q] <= in_i;
    end
  end

  always_comb begin
    out_valid_o = 1'b0;
    out_o       = '0;
    if (delay_q == '0) begin
      out_valid_o = 1'b1;
      out_o       = in_i;
    end else if (fill_q >= delay_q) begin
      out_valid_o = 1'b1;
      out_o       = mem_q[rp];
    end
  end

  assign delay_q_o = delay_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_delay_line.sv
`default_nettype none

module tb_prog_delay_line;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, cfg_we;
  logic [47:0] din;
  logic [6:0]  cfg_d;
  logic [6:0]  dq;
  logic [47:0] dout;
  logic        dval;

  logic        en48, cfg_we48;
  logic [47:0] din48;
  logic [5:0]  cfg_d48;
  logic [5:0]  dq48;
  logic [47:0] dout48;
  logic        dval48;

  int tests = 0;
  int fails = 0;

  // Reference model for the 64-deep instance: the active delay and the
  // samples accepted since the last flush (only the newest 64 are kept,
  // which is also the saturated fill level).
  int          m_d;
  logic [47:0] m_hist[$];

  always #5 clk = ~clk;

  prog_delay_line #(.WIDTH(24), .LANES(2), .MAX_DELAY(64), .DEFAULT_DELAY(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in_i(din), .cfg_we_i(cfg_we),
    .cfg_delay_i(cfg_d), .delay_q_o(dq), .out_o(dout), .out_valid_o(dval)
  );

  prog_delay_line #(.WIDTH(24), .LANES(2), .MAX_DELAY(48), .DEFAULT_DELAY(48)) dut48 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en48), .in_i(din48), .cfg_we_i(cfg_we48),
    .cfg_delay_i(cfg_d48), .delay_q_o(dq48), .out_o(dout48), .out_valid_o(dval48)
  );

  function automatic logic [47:0] rnd48();
    return {24'($urandom), 24'($urandom)};
  endfunction

  // Expected {valid, out} for the inputs currently presented.
  function automatic logic [48:0] m_expect();
    if (m_d == 0) return {1'b1, din};
    if (m_hist.size() >= m_d) return {1'b1, m_hist[m_hist.size() - m_d]};
    return '0;
  endfunction

  task automatic m_reset();
    m_d = 64;
    m_hist.delete();
  endtask

  task automatic apply(input logic e, input logic [47:0] x, input logic we, input logic [6:0] cd);
    @(negedge clk);
    en = e; din = x; cfg_we = we; cfg_d = cd;
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    if (cfg_we) begin
      m_hist.delete();
      m_d = (cfg_d > 7'd64) ? 64 : int'(cfg_d);
    end else if (en) begin
      m_hist.push_back(din);
      if (m_hist.size() > 64) void'(m_hist.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 0; cfg_we = 0; cfg_d = 0; din = rnd48();
    en48 = 0; cfg_we48 = 0; cfg_d48 = 0; din48 = 0;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({dq, dval, dout} !== {7'd64, 1'b0, 48'd0}) begin
      fails++;
      $display("FAIL reset_state: got delay=%0d valid=%0b out=%h, expected delay=64 valid=0 out=0", dq, dval, dout);
    end
    tests++;
    if ({dq48, dval48} !== {6'd48, 1'b0}) begin
      fails++;
      $display("FAIL reset_state48: got delay=%0d valid=%0b, expected delay=48 valid=0", dq48, dval48);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_default_fill();
    logic [48:0] exp;
    for (int i = 0; i < 200; i++) begin
      apply(1'b1, {24'(1000 + i), 24'(i)}, 1'b0, 7'd0);
      exp = m_expect();
      tests++;
      if ({dval, dout} !== exp) begin
        fails++;
        $display("FAIL default_fill i=%0d: got valid=%0b out=%h, expected valid=%0b out=%h", i, dval, dout, exp[48], exp[47:0]);
      end
      if (i == 64 || i == 199) begin
        exp = (i == 64) ? {1'b1, 24'd1000, 24'd0} : {1'b1, 24'd1135, 24'd135};
        tests++;
        if ({dval, dout} !== exp) begin
          fails++;
          $display("FAIL default_point i=%0d: got valid=%0b out=%h, expected valid=1 out=%h", i, dval, dout, exp[47:0]);
        end
      end
      commit();
    end
  endtask

  task automatic test_cfg5();
    logic [48:0] exp;
    apply(1'b0, rnd48(), 1'b1, 7'd5);
    commit();
    for (int i = 0; i <= 20; i++) begin
      apply(1'b1, {24'(1000 + i), 24'(i)}, 1'b0, 7'd0);
      exp = m_expect();
      tests++;
      if ({dval, dout} !== exp) begin
        fails++;
        $display("FAIL cfg5_stream i=%0d: got valid=%0b out=%h, expected valid=%0b out=%h", i, dval, dout, exp[48], exp[47:0]);
      end
      if (i == 0) begin
        tests++;
        if (dq !== 7'd5) begin
          fails++;
          $display("FAIL cfg5_delay: got %0d, expected 5", dq);
        end
      end
      if (i == 4 || i == 5 || i == 20) begin
        exp = (i == 4) ? 49'd0 : {1'b1, 24'd0, 24'(i - 5)};
        tests++;
        if ({dval, dout[23:0]} !== {exp[48], exp[23:0]}) begin
          fails++;
          $display("FAIL cfg5_point i=%0d: got valid=%0b lane0=%0d, expected valid=%0b lane0=%0d", i, dval, dout[23:0], exp[48], exp[23:0]);
        end
      end
      commit();
    end
  endtask

  task automatic test_stall();
    logic [48:0] exp, prev;
    logic        prev_en;
    prev_en = 1'b1;
    prev = '0;
    for (int i = 0; i < 120; i++) begin
      apply(1'($urandom_range(0, 1)), rnd48(), 1'b0, 7'd0);
      exp = m_expect();
      tests++;
      if ({dval, dout} !== exp) begin
        fails++;
        $display("FAIL stall_stream i=%0d: got valid=%0b out=%h, expected valid=%0b out=%h", i, dval, dout, exp[48], exp[47:0]);
      end
      if (!prev_en) begin
        tests++;
        if ({dval, dout} !== prev) begin
          fails++;
          $display("FAIL stall_hold i=%0d: got valid=%0b out=%h, expected held valid=%0b out=%h", i, dval, dout, prev[48], prev[47:0]);
        end
      end
      prev    = exp;
      prev_en = en;
      commit();
    end
  endtask

  task automatic test_coincident();
    logic [48:0] exp;
    logic [47:0] s0;
    s0 = '0;
    apply(1'b0, rnd48(), 1'b1, 7'd10);
    commit();
    for (int i = 0; i < 15; i++) begin
      apply(1'b1, rnd48(), 1'b0, 7'd0);
      commit();
    end
    apply(1'b1, rnd48(), 1'b1, 7'd3);
    exp = m_expect();
    tests++;
    if ({dq, dval, dout} !== {7'd10, exp}) begin
      fails++;
      $display("FAIL coincident_old_delay: got delay=%0d valid=%0b out=%h, expected delay=10 valid=%0b out=%h", dq, dval, dout, exp[48], exp[47:0]);
    end
    commit();
    apply(1'b0, rnd48(), 1'b0, 7'd0);
    tests++;
    if ({dq, dval, dout} !== {7'd3, 1'b0, 48'd0}) begin
      fails++;
      $display("FAIL coincident_flush: got delay=%0d valid=%0b out=%h, expected delay=3 valid=0 out=0", dq, dval, dout);
    end
    commit();
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, rnd48(), 1'b0, 7'd0);
      if (k == 0) s0 = din;
      exp = m_expect();
      tests++;
      if ({dval, dout} !== exp) begin
        fails++;
        $display("FAIL coincident_refill k=%0d: got valid=%0b out=%h, expected valid=%0b out=%h", k, dval, dout, exp[48], exp[47:0]);
      end
      if (k == 3) begin
        tests++;
        if ({dval, dout} !== {1'b1, s0}) begin
          fails++;
          $display("FAIL coincident_first: got valid=%0b out=%h, expected valid=1 out=%h", dval, dout, s0);
        end
      end
      commit();
    end
  endtask

  task automatic test_delay0();
    apply(1'b0, rnd48(), 1'b1, 7'd0);
    commit();
    for (int i = 0; i < 30; i++) begin
      apply(1'($urandom_range(0, 1)), rnd48(), 1'b0, 7'd0);
      tests++;
      if ({dq, dval, dout} !== {7'd0, 1'b1, din}) begin
        fails++;
        $display("FAIL delay0 i=%0d: got delay=%0d valid=%0b out=%h, expected delay=0 valid=1 out=%h", i, dq, dval, dout, din);
      end
      commit();
    end
  endtask

  task automatic test_clamp();
    logic [48:0] exp;
    apply(1'b0, rnd48(), 1'b1, 7'd100);
    commit();
    apply(1'b0, rnd48(), 1'b0, 7'd0);
    tests++;
    if (dq !== 7'd64) begin
      fails++;
      $display("FAIL clamp_delay: got %0d, expected 64", dq);
    end
    commit();
    for (int i = 0; i < 70; i++) begin
      apply(1'b1, rnd48(), 1'b0, 7'd0);
      exp = m_expect();
      tests++;
      if ({dval, dout} !== exp) begin
        fails++;
        $display("FAIL clamp_stream i=%0d: got valid=%0b out=%h, expected valid=%0b out=%h", i, dval, dout, exp[48], exp[47:0]);
      end
      commit();
    end
    // Same value again must still flush.
    apply(1'b0, rnd48(), 1'b1, 7'd64);
    commit();
    apply(1'b0, rnd48(), 1'b0, 7'd0);
    tests++;
    if ({dq, dval, dout} !== {7'd64, 1'b0, 48'd0}) begin
      fails++;
      $display("FAIL repeat_flush: got delay=%0d valid=%0b out=%h, expected delay=64 valid=0 out=0", dq, dval, dout);
    end
    commit();
  endtask

  task automatic test_wrap48();
    logic [47:0] seen [300];
    logic [48:0] exp;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      en48 = 1'b1;
      din48 = rnd48();
      seen[i] = din48;
      #1;
      exp = (i < 48) ? 49'd0 : {1'b1, seen[i - 48]};
      tests++;
      if ({dval48, dout48} !== exp) begin
        fails++;
        $display("FAIL wrap48 i=%0d: got valid=%0b out=%h, expected valid=%0b out=%h", i, dval48, dout48, exp[48], exp[47:0]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    en48 = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [48:0] exp;
    apply(1'b0, rnd48(), 1'b1, 7'd4);
    commit();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, rnd48(), 1'b0, 7'd0);
      commit();
    end
    @(negedge clk);
    en = 1'b0; cfg_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({dq, dval, dout} !== {7'd64, 1'b0, 48'd0}) begin
      fails++;
      $display("FAIL async_reset: got delay=%0d valid=%0b out=%h, expected delay=64 valid=0 out=0", dq, dval, dout);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      apply(1'b1, rnd48(), 1'b0, 7'd0);
      exp = m_expect();
      tests++;
      if ({dval, dout} !== exp) begin
        fails++;
        $display("FAIL post_reset i=%0d: got valid=%0b out=%h, expected valid=%0b out=%h", i, dval, dout, exp[48], exp[47:0]);
      end
      commit();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before time 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_default_fill();
    test_cfg5();
    test_stall();
    test_coincident();
    test_delay0();
    test_clamp();
    test_wrap48();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
